// File: rtl/rx_symbol_aligner.sv
// Serial-to-parallel receive aligner: locks 10-bit symbol framing onto K28.5 commas.
// Symbol out one edge after the boundary cycle; no backpressure, runs on the bit clock.
module rx_symbol_aligner #(
  parameter int LOCK_COUNT = 2,
  parameter int LOSS_COUNT = 4
) (
  input  logic       TRANSCLK,
  input  logic       Reset,
  input  logic       data_in,
  input  logic       RXIDLE,
  output logic [9:0] data_out,
  output logic       symbol_valid,
  output logic       comma_det,
  output logic       RXVALID,
  output logic       misalign_err
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [3:0] LOCK_TH   = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TH   = 4'(LOSS_COUNT);

  state_t     state;
  logic [9:0] sr;
  logic [3:0] p;
  logic [3:0] good_cnt;
  logic [3:0] bad_cnt;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic       comma_match;
  logic       boundary;

  assign comma_match = (sr == K28_5_RDN) || (sr == K28_5_RDP);
  assign boundary    = (p == 4'd9);
  assign good_inc    = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  assign bad_inc     = (bad_cnt  == 4'hF) ? bad_cnt  : bad_cnt  + 4'd1;

  // RXVALID mirrors the next state; it is only touched on transitions into or out of LOCKED.
  always_ff @(posedge TRANSCLK) begin
    if (Reset) begin
      state        <= HUNT;
      sr           <= 10'h000;
      p            <= 4'd0;
      good_cnt     <= 4'd0;
      bad_cnt      <= 4'd0;
      data_out     <= 10'h000;
      symbol_valid <= 1'b0;
      comma_det    <= 1'b0;
      misalign_err <= 1'b0;
      RXVALID      <= 1'b0;
    end else begin
      sr           <= {sr[8:0], data_in};
      p            <= boundary ? 4'd0 : p + 4'd1;
      symbol_valid <= 1'b0;
      comma_det    <= 1'b0;
      misalign_err <= 1'b0;

      if (RXIDLE) begin
        state    <= HUNT;
        p        <= 4'd0;
        good_cnt <= 4'd0;
        bad_cnt  <= 4'd0;
        RXVALID  <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (comma_match) begin
              // The comma cycle itself acts as a boundary, so framing restarts here.
              p        <= 4'd0;
              good_cnt <= 4'd1;
              bad_cnt  <= 4'd0;
              if (LOCK_TH <= 4'd1) begin
                state        <= LOCKED;
                RXVALID      <= 1'b1;
                data_out     <= sr;
                symbol_valid <= 1'b1;
                comma_det    <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end
          end

          CONFIRM: begin
            if (comma_match) begin
              if (boundary) begin
                good_cnt <= good_inc;
                if (good_inc >= LOCK_TH) begin
                  state        <= LOCKED;
                  RXVALID      <= 1'b1;
                  bad_cnt      <= 4'd0;
                  data_out     <= sr;
                  symbol_valid <= 1'b1;
                  comma_det    <= 1'b1;
                end
              end else begin
                p        <= 4'd0;
                good_cnt <= 4'd1;
              end
            end
          end

          LOCKED: begin
            if (boundary) begin
              data_out     <= sr;
              symbol_valid <= 1'b1;
              comma_det    <= comma_match;
              if (comma_match) begin
                bad_cnt <= 4'd0;
              end
            end else if (comma_match) begin
              // Framing is never moved while locked; only repeated evidence drops lock.
              misalign_err <= 1'b1;
              bad_cnt      <= bad_inc;
              if (bad_inc >= LOSS_TH) begin
                state    <= HUNT;
                RXVALID  <= 1'b0;
                good_cnt <= 4'd0;
                bad_cnt  <= 4'd0;
              end
            end
          end

          default: begin
            state   <= HUNT;
            RXVALID <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/rx_symbol_aligner.md
# rx_symbol_aligner

Receive-path serial-to-parallel converter with K28.5 comma alignment. It sits directly downstream of the receiver electrical sub-block. It takes that block's recovered serial bit and idle indication and produces aligned 10-bit symbols plus a lock indication for the 8b/10b decode and status logic. It runs entirely in the bit-clock domain.

## Interface
- LOCK_COUNT, default 2: consecutive aligned K28.5 symbols required to declare lock (legal 1..15).
- LOSS_COUNT, default 4: consecutive misaligned K28.5 symbols, while locked, that drop lock (legal 1..15).

- TRANSCLK  input  1  bit clock; all logic on its rising edge. This is the block's single clock.
- Reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial receive bit; 8b/10b bit "a" first.
- RXIDLE  input  1  electrical idle from the receiver electrical sub-block; 1 = line idle.
- data_out  output  10  aligned symbol; bit 9 = first-received bit (a), bit 0 = last (j).
- symbol_valid  output  1  one-cycle strobe; data_out holds a new symbol.
- comma_det  output  1  qualifies symbol_valid; current symbol is K28.5 (either disparity).
- RXVALID  output  1  1 = aligner locked.
- misalign_err  output  1  one-cycle pulse; a K28.5 was seen off the locked boundary.

## Operation
- **Shift register**
  - sr[9:0] <= {sr[8:0], data_in} every cycle, including during RXIDLE.
  - Window = sr[9:0].
  - Comma match when window == 10'b0011111010 (RD-) or 10'b1100000101 (RD+).
- **Phase counter** p (0..9, wraps 9->0). A cycle is a boundary when p == 9.
- **HUNT** (reset state)
  - Nothing is emitted.
  - On a match in any cycle: that cycle is treated as a boundary, p <= 0, good_cnt <= 1, go to CONFIRM.
  - If LOCK_COUNT == 1, go directly to LOCKED instead.
- **CONFIRM**
  - Match at a boundary: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED.
  - Non-comma at a boundary: stay in CONFIRM, no count change.
  - Match at a non-boundary: realign. p <= 0, good_cnt <= 1, stay in CONFIRM.
  - No symbols are emitted in CONFIRM.
- **LOCKED**
  - At every boundary: data_out <= window, symbol_valid <= 1, comma_det <= match.
  - The boundary that causes the CONFIRM->LOCKED transition also emits its symbol.
  - Aligned match: bad_cnt <= 0.
  - Match at a non-boundary: misalign_err <= 1, bad_cnt++. When bad_cnt reaches LOSS_COUNT, go to HUNT. No realignment while locked.
- **RXIDLE == 1**
  - Next state is HUNT; good_cnt, bad_cnt and p are cleared.
  - Comma matches are ignored that cycle.
  - symbol_valid, comma_det and misalign_err are 0.
  - data_out holds its last value.
- RXVALID <= (next state == LOCKED), registered.
- Counters are 4 bits wide and saturate at 15. p wraps modulo 10.

## Timing
- Reset values:
  - data_out = 10'h000
  - symbol_valid = 0, comma_det = 0, RXVALID = 0, misalign_err = 0
  - sr = 0, p = 0, good_cnt = 0, bad_cnt = 0, state = HUNT
- Priority: Reset > RXIDLE > comma logic.
- Reset asserted mid-symbol discards the partial symbol. Re-lock needs the full LOCK_COUNT sequence again.
- Latency:
  - Last bit (j) of a symbol is sampled at edge E, so the window holds the full symbol after E.
  - data_out, symbol_valid and comma_det are valid after edge E+1.
- Lock latency:
  - RXVALID rises after the edge that follows the boundary of the LOCK_COUNT-th aligned comma.
  - With LOCK_COUNT=2 this is 10 bit times after the first comma's boundary cycle, plus 1.
- Symbol rate: while locked, symbol_valid pulses exactly once every 10 cycles, never on consecutive cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
1. **Reset:** Reset high 3 cycles with random data_in -> all outputs 0. RXVALID stays 0 until a comma sequence is received.
2. **Lock:**
   - Stimulus: 3 random bits, K28.5 RD- (0011111010), D21.5 (1010101010), K28.5 RD+ (1100000101).
   - Required: RXVALID=1 one edge after the second comma's boundary; same edge data_out=10'b1100000101, comma_det=1, symbol_valid=1.
3. **Data stream:** after lock, 5x D21.5 -> symbol_valid exactly every 10 cycles, data_out=10'h2AA, comma_det=0, misalign_err=0.
4. **Bit slip:**
   - Stimulus: while locked, insert one extra bit, then send 4 K28.5 at the new phase.
   - Required: misalign_err pulses 4 times; RXVALID drops after the 4th; 2 further aligned commas at the new phase re-lock with data_out correct.
5. **Idle:** RXIDLE=1 for 20 cycles while locked -> RXVALID=0 next edge, no symbol_valid during idle, then a full re-lock sequence is required.
6. **CONFIRM realign:** in CONFIRM, K28.5 arrives 3 bits early -> no RXVALID. The next comma aligned to the new phase locks (LOCK_COUNT=2).
